// File: rtl/alarm_setter.sv
// Purpose: debounces mode/inc/set buttons and runs the time/alarm edit FSM feeding top_alarm.
// Latency: button press -> event pulse at DEBOUNCE_CYCLES+3, register update at DEBOUNCE_CYCLES+4.
// Backpressure: none; events are single-cycle pulses and outputs are plain registered levels.
module alarm_setter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_set,
    output logic [3:0] hourdec_init,
    output logic [3:0] hourone_init,
    output logic [3:0] mindec_init,
    output logic [3:0] minone_init,
    output logic       init_load,
    output logic [3:0] hourdec_bud,
    output logic [3:0] hourone_bud,
    output logic [3:0] mindec_bud,
    output logic [3:0] minone_bud,
    output logic       bud_en,
    output logic [2:0] edit_state
);

    // Counter must be able to hold DEBOUNCE_CYCLES itself: the level flips on the
    // mismatching cycle seen while the counter already sits at the limit.
    localparam int                CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    // Button lane indices inside the packed button vectors.
    localparam int B_MODE = 0;
    localparam int B_INC  = 1;
    localparam int B_SET  = 2;

    // Edit states; 5..7 are unreachable and fall back to IDLE.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_T_HOUR = 3'd1;
    localparam logic [2:0] ST_T_MIN  = 3'd2;
    localparam logic [2:0] ST_A_HOUR = 3'd3;
    localparam logic [2:0] ST_A_MIN  = 3'd4;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       db_q, db_d;
    logic [2:0]       db_prev_q, db_prev_d;
    logic [2:0]       evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    assign btn_raw = {btn_set, btn_inc, btn_mode};

    // Synchronize, debounce by counting disagreeing cycles, and pulse on debounced rise.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        evt_d     = db_q & ~db_prev_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LIMIT) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Conditioning registers; reset clears synchronizers, counters and levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            evt_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            evt_q     <= evt_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // BCD increment helpers ({tens, ones} packed in one byte)
    // ------------------------------------------------------------------
    function automatic logic [7:0] hour_inc(input logic [7:0] v);
        logic [3:0] dec;
        logic [3:0] one;
        dec = v[7:4];
        one = v[3:0];
        if (dec >= 4'd2 && one >= 4'd3) begin
            return 8'h00;
        end else if (one >= 4'd9) begin
            return {dec + 4'd1, 4'd0};
        end else begin
            return {dec, one + 4'd1};
        end
    endfunction

    function automatic logic [7:0] min_inc(input logic [7:0] v);
        logic [3:0] dec;
        logic [3:0] one;
        dec = v[7:4];
        one = v[3:0];
        if (one >= 4'd9) begin
            if (dec >= 4'd5) begin
                return 8'h00;
            end else begin
                return {dec + 4'd1, 4'd0};
            end
        end else begin
            return {dec, one + 4'd1};
        end
    endfunction

    // ------------------------------------------------------------------
    // Edit state machine
    // ------------------------------------------------------------------
    logic       ev_mode, ev_inc, ev_set;
    logic [2:0] state_q, state_d;
    logic [7:0] sh_hr_q, sh_hr_d;   // time shadow being edited
    logic [7:0] sh_mn_q, sh_mn_d;
    logic [7:0] ld_hr_q, ld_hr_d;   // last time handed to the clock
    logic [7:0] ld_mn_q, ld_mn_d;
    logic [7:0] al_hr_q, al_hr_d;   // alarm time
    logic [7:0] al_mn_q, al_mn_d;
    logic       bud_en_q, bud_en_d;
    logic       init_load_q, init_load_d;
    logic       editing_time;

    // Same-cycle events resolve mode > inc > set; losers are dropped.
    assign ev_mode = evt_q[B_MODE];
    assign ev_inc  = evt_q[B_INC] & ~evt_q[B_MODE];
    assign ev_set  = evt_q[B_SET] & ~evt_q[B_MODE] & ~evt_q[B_INC];

    // Next-state and field updates for the edit FSM.
    always_comb begin
        state_d     = state_q;
        sh_hr_d     = sh_hr_q;
        sh_mn_d     = sh_mn_q;
        ld_hr_d     = ld_hr_q;
        ld_mn_d     = ld_mn_q;
        al_hr_d     = al_hr_q;
        al_mn_d     = al_mn_q;
        bud_en_d    = bud_en_q;
        init_load_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ev_mode) begin
                    state_d = ST_T_HOUR;
                    sh_hr_d = 8'h00;
                    sh_mn_d = 8'h00;
                end else if (ev_set) begin
                    bud_en_d = ~bud_en_q;
                end
            end
            ST_T_HOUR: begin
                if (ev_mode) begin
                    state_d = ST_T_MIN;
                end else if (ev_inc) begin
                    sh_hr_d = hour_inc(sh_hr_q);
                end
            end
            ST_T_MIN: begin
                if (ev_mode) begin
                    // Commit the shadow; the strobe lines up with entry to A_HOUR.
                    state_d     = ST_A_HOUR;
                    ld_hr_d     = sh_hr_q;
                    ld_mn_d     = sh_mn_q;
                    init_load_d = 1'b1;
                end else if (ev_inc) begin
                    sh_mn_d = min_inc(sh_mn_q);
                end
            end
            ST_A_HOUR: begin
                if (ev_mode) begin
                    state_d = ST_A_MIN;
                end else if (ev_inc) begin
                    al_hr_d = hour_inc(al_hr_q);
                end
            end
            ST_A_MIN: begin
                if (ev_mode) begin
                    state_d = ST_IDLE;
                end else if (ev_inc) begin
                    al_mn_d = min_inc(al_mn_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Edit FSM registers; reset aborts any edit in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sh_hr_q     <= '0;
            sh_mn_q     <= '0;
            ld_hr_q     <= '0;
            ld_mn_q     <= '0;
            al_hr_q     <= '0;
            al_mn_q     <= '0;
            bud_en_q    <= 1'b0;
            init_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_hr_q     <= sh_hr_d;
            sh_mn_q     <= sh_mn_d;
            ld_hr_q     <= ld_hr_d;
            ld_mn_q     <= ld_mn_d;
            al_hr_q     <= al_hr_d;
            al_mn_q     <= al_mn_d;
            bud_en_q    <= bud_en_d;
            init_load_q <= init_load_d;
        end
    end

    // While editing the time, the init digits show the live shadow.
    assign editing_time = (state_q == ST_T_HOUR) || (state_q == ST_T_MIN);

    assign {hourdec_init, hourone_init} = editing_time ? sh_hr_q : ld_hr_q;
    assign {mindec_init,  minone_init}  = editing_time ? sh_mn_q : ld_mn_q;
    assign init_load                    = init_load_q;
    assign {hourdec_bud, hourone_bud}   = al_hr_q;
    assign {mindec_bud,  minone_bud}    = al_mn_q;
    assign bud_en                       = bud_en_q;
    assign edit_state                   = state_q;

endmodule

// File: doc/alarm_setter.md
# alarm_setter

User-input front end for the alarm clock. It debounces three raw push-buttons and runs an edit state machine that lets the user set the current time and the alarm time in BCD. It drives the `*_init` digits with a one-cycle load strobe, and the `*_bud` digits plus `bud_en`, into `top_alarm`. In other words, it is the writer side of the time/alarm settings interface that `top_alarm` consumes.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable synchronized cycles required before a button level change is accepted (10 ms at 100 MHz).
- `clk`: input, 1 bit. System clock, 100 MHz.
- `rst`: input, 1 bit. Synchronous, active-high reset.
- `btn_mode`: input, 1 bit. Raw asynchronous button; advances the edit state.
- `btn_inc`: input, 1 bit. Raw asynchronous button; increments the field being edited.
- `btn_set`: input, 1 bit. Raw asynchronous button; toggles `bud_en` in IDLE.
- `hourdec_init`, `hourone_init`, `mindec_init`, `minone_init`: output, 4 bits each. BCD time to load into the clock.
- `init_load`: output, 1 bit. One-cycle strobe; the `*_init` digits are valid while it is high.
- `hourdec_bud`, `hourone_bud`, `mindec_bud`, `minone_bud`: output, 4 bits each. BCD alarm time.
- `bud_en`: output, 1 bit. Alarm enable.
- `edit_state`: output, 3 bits. Current state encoding, for the LED/display indicator.

## Operation
- **Button conditioning** (per button):
  - 2-flop synchronizer.
  - Debounce counter: the debounced level takes the synchronized value after `DEBOUNCE_CYCLES` consecutive cycles in which the synchronized value differs from the current debounced level. Any agreeing cycle clears the counter.
  - A rising edge of the debounced level produces a one-cycle event pulse. Releases generate no event.
- **States:** IDLE=0, T_HOUR=1, T_MIN=2, A_HOUR=3, A_MIN=4. Values 5–7 are unreachable; if decoded, go to IDLE.
- **Mode event:** IDLE→T_HOUR→T_MIN→A_HOUR→A_MIN→IDLE.
  - On entry to T_HOUR, the time shadow registers are cleared to 00:00.
  - On the T_MIN→A_HOUR transition, `init_load` pulses for one cycle with the shadow value on the `*_init` outputs.
- **Inc event:**
  - T_HOUR / A_HOUR: the hour pair increments with BCD wrap, 09→10, 19→20, 23→00.
  - T_MIN / A_MIN: the minute pair increments with BCD wrap, x9→(x+1)0, 59→00.
  - Only hours or minutes change; the other field is never touched.
  - IDLE: ignored.
- **Set event:** in IDLE, toggles `bud_en`. Ignored in all other states.
- **Simultaneous events in the same cycle:** priority mode > inc > set. Lower-priority events that cycle are dropped.
- **Output registers:**
  - The `*_bud` outputs are written directly during A_HOUR/A_MIN.
  - The `*_init` outputs hold the last loaded value except while in T_HOUR/T_MIN, when they reflect the shadow value (`init_load` still low).
- Digits never leave valid BCD ranges:
  - `hourdec` 0–2
  - `hourone` 0–9, and 0–3 when `hourdec`=2
  - `mindec` 0–5
  - `minone` 0–9

## Timing
- **Reset:** all digit outputs 0, `bud_en`=0, `init_load`=0, `edit_state`=IDLE. Synchronizers, debounce counters and debounced levels are cleared to 0.
- Reset asserted mid-edit aborts the edit: no `init_load` pulse, and alarm digits return to 0.
- A button held high from cycle 0, with the first sampling edge at cycle 0, produces its event pulse at cycle `DEBOUNCE_CYCLES`+3. The register update is visible at cycle `DEBOUNCE_CYCLES`+4.
- `init_load` is high exactly one cycle, coincident with `edit_state` changing to A_HOUR.
- A glitch shorter than `DEBOUNCE_CYCLES` produces no event.
- A held button produces exactly one event (no auto-repeat).
- Throughput: at most one event per button per `2*DEBOUNCE_CYCLES` cycles.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Reset/debounce:** after reset, pulse `btn_inc` high for 3 cycles → no event, outputs all 0. Then hold it for 10 cycles in IDLE → still no change, `edit_state`=0.
- **Set time:** mode, then inc ×13, mode, then inc ×45, mode → exactly one `init_load` pulse with `init` = 1,3,4,5; `edit_state`=3; `bud` still 0,0,0,0.
- **Wrap:** in A_HOUR, inc ×24 → hour returns to 00. Passes through 09→10 and 19→20, and 23→00 is observed. In A_MIN, inc ×60 → 59→00 occurs, and `hourdec`/`hourone` are unchanged.
- **Alarm and enable:** set alarm to 07:30 and return to IDLE → `bud` = 0,7,3,0 with no `init_load`. Then `btn_set` → `bud_en`=1; `btn_set` again → 0. `btn_set` while in T_HOUR → `bud_en` unchanged.
- **Simultaneous:** `btn_mode` and `btn_inc` released-to-pressed in the same cycle while in T_HOUR → state becomes T_MIN and the hours are unchanged.
- **Reset mid-edit:** in T_MIN with shadow 12:34, assert `rst` for 1 cycle → `init_load` never pulses, `edit_state`=0, all digits 0.
